integral_image_calc: RTL and testbench
======================================

Name: integral_image_calc

Overview:
- Front stage of the Viola-Jones detection pipeline; consumes a raster-order grayscale pixel stream, one frame at a time.
- Emits the integral image value ii(x,y) for each pixel, plus frame/row position strobes.
- Its ii/valid/position outputs feed the window-extraction stage; `delay_signal` instances re-align those control strobes with the downstream arithmetic.
- Holds one row of running column sums internally.

Parameters:
- PIX_WIDTH, 8: input pixel width (unsigned).
- IMG_WIDTH, 320: pixels per row.
- IMG_HEIGHT, 240: rows per frame.
- II_WIDTH, 25: integral output width; must be at least PIX_WIDTH+clog2(IMG_WIDTH)+clog2(IMG_HEIGHT).

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous, active-low reset
- pix_i  input  PIX_WIDTH  pixel value
- pix_valid_i  input  1  pix_i is valid this cycle
- pix_sof_i  input  1  first pixel of frame; qualified by pix_valid_i
- ii_o  output  II_WIDTH  integral value ii(x,y)
- ii_valid_o  output  1  ii_o valid
- ii_sof_o  output  1  ii_o belongs to pixel (0,0)
- ii_eol_o  output  1  ii_o belongs to column IMG_WIDTH-1
- ii_eof_o  output  1  ii_o belongs to the last pixel of the frame
- busy_o  output  1  frame in progress (FSM in ACTIVE)
- frame_err_o  output  1  one-cycle pulse: a valid pixel was dropped

Behaviour:
- Reset (rst_i=0, async): all outputs are 0; FSM is IDLE; x=0, y=0; row_acc=0.
- Row buffer contents are don't-care at reset; they are never read while y=0.
- Definitions:
  - row_acc = running sum of pixels in the current row.
  - colbuf[x] = ii(x,y-1); one entry per column, II_WIDTH bits.
  - ii(x,y) = row_acc_new + (y==0 ? 0 : colbuf[x]), where row_acc_new = (x==0 ? 0 : row_acc) + pix_i.
  - colbuf[x] is written with ii(x,y) in the same cycle it is read.
- All sums are unsigned and modulo 2^II_WIDTH; there is no saturation.
- Latency: exactly 1 cycle. A pixel accepted at cycle N drives ii_o and its strobes at N+1. No bubbles are inserted; gaps in pix_valid_i pass through as gaps in ii_valid_o.
- No backpressure; every accepted pixel produces exactly one output.
- ii_o holds its last value when ii_valid_o=0. All strobes are 0 when ii_valid_o=0.
- FSM IDLE:
  - Waits for pix_valid_i & pix_sof_i; that pixel is processed as (0,0) and the FSM goes to ACTIVE.
  - A valid pixel without sof is dropped and pulses frame_err_o at N+1.
- FSM ACTIVE:
  - Each valid pixel advances x. At x==IMG_WIDTH-1, x wraps to 0 and y increments.
  - At the last pixel (x=IMG_WIDTH-1, y=IMG_HEIGHT-1), ii_eof_o is raised for it, counters clear, and the FSM returns to IDLE.
- busy_o is 1 in ACTIVE only.
- Mid-frame sof (ACTIVE, valid & sof):
  - The current frame is abandoned.
  - The pixel is processed as (0,0) of a new frame and frame_err_o pulses.
  - No eof is emitted for the abandoned frame.
- Single-frame case: sof and eof on the same pixel cannot occur, because IMG_WIDTH*IMG_HEIGHT>1 is required.
- Reset mid-frame: the output is killed immediately (async) and the next frame requires sof.

Optional Feature:
- Macro: INTEGRAL_IMAGE_SQ_EN.
- When defined:
  - Adds parameter SQ_II_WIDTH (default 33).
  - Adds output sq_ii_o (SQ_II_WIDTH bits): the squared integral image, computed identically with pix_i*pix_i in place of pix_i.
  - Uses a second row buffer.
  - Same latency, same strobes, and same hold behaviour as ii_o; used by window variance normalisation.
- When undefined: the port, parameter and second buffer are absent; all other behaviour is identical.

Test Plan:
All scenarios use IMG_WIDTH=4, IMG_HEIGHT=3, II_WIDTH=8.
- All-ones frame, continuous valid, sof on first pixel:
  - ii_o sequence is 1,2,3,4, 2,4,6,8, 3,6,9,12.
  - ii_sof_o on the 1st output, ii_eol_o on the 4th/8th/12th, ii_eof_o on the 12th.
  - busy_o falls one cycle after the last pixel is accepted.
- Pixel value = x+4y (0..11), pix_valid_i toggling 1/0:
  - Last ii_o=66.
  - ii_valid_o mirrors the input pattern delayed by 1 cycle.
- Pixels 0xFF everywhere: ii(3,2)=12*255 mod 256=244; no saturation.
- Three valid pixels without sof after reset: all dropped, three frame_err_o pulses, ii_valid_o stays 0, busy_o=0.
- sof at pixel (2,1) of an all-ones frame:
  - frame_err_o pulses and the next output is ii=1 with ii_sof_o=1.
  - No ii_eof_o for the first frame; the second frame completes with 12.
- rst_i low at pixel (1,1), then release and a new all-ones frame:
  - All outputs are 0 during reset.
  - The new frame outputs the same sequence as scenario 1 (stale colbuf is ignored).
  - With INTEGRAL_IMAGE_SQ_EN, pixel 2 everywhere gives final sq_ii_o=48.

Source files
------------

// File: rtl/integral_image_calc.sv
// ============================================================================
// Module   : integral_image_calc
// Brief    : Streaming integral-image generator (1-cycle latency, one row buffer).
//            Optional squared integral image output when INTEGRAL_IMAGE_SQ_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module integral_image_calc #(
  parameter int PIX_WIDTH   = 8,
  parameter int IMG_WIDTH   = 320,
  parameter int IMG_HEIGHT  = 240,
  parameter int II_WIDTH    = 25
`ifdef INTEGRAL_IMAGE_SQ_EN
  ,
  parameter int SQ_II_WIDTH = 33
`endif
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [PIX_WIDTH-1:0]   pix_i,
  input  logic                   pix_valid_i,
  input  logic                   pix_sof_i,
  output logic [II_WIDTH-1:0]    ii_o,
  output logic                   ii_valid_o,
  output logic                   ii_sof_o,
  output logic                   ii_eol_o,
  output logic                   ii_eof_o,
  output logic                   busy_o,
  output logic                   frame_err_o
`ifdef INTEGRAL_IMAGE_SQ_EN
  ,
  output logic [SQ_II_WIDTH-1:0] sq_ii_o
`endif
);

  localparam int c_xw = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int c_yw = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [c_xw-1:0] c_x_last = c_xw'(IMG_WIDTH - 1);
  localparam logic [c_yw-1:0] c_y_last = c_yw'(IMG_HEIGHT - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t              r_state;
  logic [c_xw-1:0]     r_x;
  logic [c_yw-1:0]     r_y;
  logic [II_WIDTH-1:0] r_row_acc;
  logic [II_WIDTH-1:0] r_colbuf [IMG_WIDTH];
  logic [II_WIDTH-1:0] r_ii;
  logic                r_ii_valid;
  logic                r_sof;
  logic                r_eol;
  logic                r_eof;
  logic                r_err;

  logic                w_is_sof;
  logic                w_accept;
  logic                w_err;
  logic [c_xw-1:0]     w_x;
  logic [c_yw-1:0]     w_y;
  logic                w_first_col;
  logic                w_first_row;
  logic                w_x_last;
  logic                w_y_last;
  logic [II_WIDTH-1:0] w_row_new;
  logic [II_WIDTH-1:0] w_ii;

  // A sof pixel always restarts at (0,0), whether idle or abandoning a frame.
  assign w_is_sof    = pix_valid_i & pix_sof_i;
  assign w_accept    = pix_valid_i & (pix_sof_i | (r_state == S_ACTIVE));
  assign w_err       = pix_valid_i & (pix_sof_i ? (r_state == S_ACTIVE) : (r_state == S_IDLE));
  assign w_x         = w_is_sof ? '0 : r_x;
  assign w_y         = w_is_sof ? '0 : r_y;
  assign w_first_col = (w_x == '0);
  assign w_first_row = (w_y == '0);
  assign w_x_last    = (w_x == c_x_last);
  assign w_y_last    = (w_y == c_y_last);
  assign w_row_new   = (w_first_col ? '0 : r_row_acc) + II_WIDTH'(pix_i);
  assign w_ii        = w_row_new + (w_first_row ? '0 : r_colbuf[w_x]);

`ifdef INTEGRAL_IMAGE_SQ_EN
  logic [SQ_II_WIDTH-1:0] r_sq_row_acc;
  logic [SQ_II_WIDTH-1:0] r_sq_colbuf [IMG_WIDTH];
  logic [SQ_II_WIDTH-1:0] r_sq_ii;
  logic [2*PIX_WIDTH-1:0] w_pix_sq;
  logic [SQ_II_WIDTH-1:0] w_sq_row_new;
  logic [SQ_II_WIDTH-1:0] w_sq_ii;

  assign w_pix_sq     = pix_i * pix_i;
  assign w_sq_row_new = (w_first_col ? '0 : r_sq_row_acc) + SQ_II_WIDTH'(w_pix_sq);
  assign w_sq_ii      = w_sq_row_new + (w_first_row ? '0 : r_sq_colbuf[w_x]);
  assign sq_ii_o      = r_sq_ii;
`endif

  // Column buffers hold the previous row's ii; contents are never read on row 0.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_colbuf[w_x] <= w_ii;
`ifdef INTEGRAL_IMAGE_SQ_EN
      r_sq_colbuf[w_x] <= w_sq_ii;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_row_acc  <= '0;
      r_ii       <= '0;
      r_ii_valid <= 1'b0;
      r_sof      <= 1'b0;
      r_eol      <= 1'b0;
      r_eof      <= 1'b0;
      r_err      <= 1'b0;
`ifdef INTEGRAL_IMAGE_SQ_EN
      r_sq_row_acc <= '0;
      r_sq_ii      <= '0;
`endif
    end else begin
      r_ii_valid <= w_accept;
      r_sof      <= w_accept & w_is_sof;
      r_eol      <= w_accept & w_x_last;
      r_eof      <= w_accept & w_x_last & w_y_last;
      r_err      <= w_err;
      if (w_accept) begin
        r_ii      <= w_ii;
        r_row_acc <= w_row_new;
`ifdef INTEGRAL_IMAGE_SQ_EN
        r_sq_ii      <= w_sq_ii;
        r_sq_row_acc <= w_sq_row_new;
`endif
        if (w_x_last) begin
          r_x <= '0;
          if (w_y_last) begin
            r_y     <= '0;
            r_state <= S_IDLE;
          end else begin
            r_y     <= w_y + 1'b1;
            r_state <= S_ACTIVE;
          end
        end else begin
          r_x     <= w_x + 1'b1;
          r_y     <= w_y;
          r_state <= S_ACTIVE;
        end
      end
    end
  end

  assign ii_o        = r_ii;
  assign ii_valid_o  = r_ii_valid;
  assign ii_sof_o    = r_sof;
  assign ii_eol_o    = r_eol;
  assign ii_eof_o    = r_eof;
  assign busy_o      = (r_state == S_ACTIVE);
  assign frame_err_o = r_err;

endmodule

`default_nettype wire

// File: tb/tb_integral_image_calc.sv
// ============================================================================
// Module   : tb_integral_image_calc
// Brief    : Directed self-checking bench for integral_image_calc (4x3 image, 8-bit ii).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_integral_image_calc;

  localparam int PIX_WIDTH   = 8;
  localparam int IMG_WIDTH   = 4;
  localparam int IMG_HEIGHT  = 3;
  localparam int II_WIDTH    = 8;
  localparam int SQ_II_WIDTH = 33;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [PIX_WIDTH-1:0] pix_i;
  logic                pix_valid_i;
  logic                pix_sof_i;
  logic [II_WIDTH-1:0] ii_o;
  logic                ii_valid_o, ii_sof_o, ii_eol_o, ii_eof_o, busy_o, frame_err_o;
`ifdef INTEGRAL_IMAGE_SQ_EN
  logic [SQ_II_WIDTH-1:0] sq_ii_o;
`endif

  always #5 clk_i = ~clk_i;

  integral_image_calc #(
    .PIX_WIDTH  (PIX_WIDTH),
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .II_WIDTH   (II_WIDTH)
`ifdef INTEGRAL_IMAGE_SQ_EN
    ,
    .SQ_II_WIDTH(SQ_II_WIDTH)
`endif
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pix_i       (pix_i),
    .pix_valid_i (pix_valid_i),
    .pix_sof_i   (pix_sof_i),
    .ii_o        (ii_o),
    .ii_valid_o  (ii_valid_o),
    .ii_sof_o    (ii_sof_o),
    .ii_eol_o    (ii_eol_o),
    .ii_eof_o    (ii_eof_o),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o)
`ifdef INTEGRAL_IMAGE_SQ_EN
    ,
    .sq_ii_o     (sq_ii_o)
`endif
  );

  typedef struct {
    bit     valid, sof, eol, eof, busy, err;
    int     ii;
    longint sq;
  } exp_t;

  exp_t   pend, expd;
  bit     m_active;
  int     m_x, m_y;
  int     img [IMG_HEIGHT][IMG_WIDTH];
  int     seen [$];
  int     n_checks = 0;
  int     n_pass   = 0;
  bit     chk_en   = 1'b0;

  // Expected outputs become visible one clock after the inputs that cause them.
  always @(posedge clk_i) expd <= pend;

  always @(negedge clk_i) begin
    if (chk_en) begin
      n_checks++;
      if (ii_valid_o === expd.valid && ii_sof_o === expd.sof && ii_eol_o === expd.eol &&
          ii_eof_o === expd.eof && busy_o === expd.busy && frame_err_o === expd.err &&
          ii_o === expd.ii[II_WIDTH-1:0])
        n_pass++;
      else
        $display("FAIL outputs t=%0t got v=%b sof=%b eol=%b eof=%b busy=%b err=%b ii=%0d exp v=%b sof=%b eol=%b eof=%b busy=%b err=%b ii=%0d",
                 $time, ii_valid_o, ii_sof_o, ii_eol_o, ii_eof_o, busy_o, frame_err_o, ii_o,
                 expd.valid, expd.sof, expd.eol, expd.eof, expd.busy, expd.err, expd.ii);
`ifdef INTEGRAL_IMAGE_SQ_EN
      n_checks++;
      if (sq_ii_o === SQ_II_WIDTH'(expd.sq)) n_pass++;
      else $display("FAIL sq_ii t=%0t got %0d exp %0d", $time, sq_ii_o, expd.sq);
`endif
      if (ii_valid_o) seen.push_back(int'(ii_o));
    end
  end

  // Model: ii is the plain rectangle sum of the pixels of the current frame.
  task automatic drive(input bit v, input bit s, input int p);
    bit acc;
    int sum;
    longint sq;
    pix_valid_i = v;
    pix_sof_i   = s;
    pix_i       = p[PIX_WIDTH-1:0];
    pend.err    = v && (s ? m_active : !m_active);
    acc         = v && (s || m_active);
    pend.valid  = acc;
    pend.sof    = acc && s;
    pend.eol    = 1'b0;
    pend.eof    = 1'b0;
    if (acc) begin
      if (s) begin m_x = 0; m_y = 0; m_active = 1'b1; end
      img[m_y][m_x] = p;
      sum = 0; sq = 0;
      for (int j = 0; j <= m_y; j++)
        for (int i = 0; i <= m_x; i++) begin
          sum += img[j][i];
          sq  += longint'(img[j][i]) * img[j][i];
        end
      pend.ii  = sum % 256;
      pend.sq  = sq % (longint'(1) << SQ_II_WIDTH);
      pend.eol = (m_x == IMG_WIDTH - 1);
      pend.eof = (m_x == IMG_WIDTH - 1) && (m_y == IMG_HEIGHT - 1);
      if (m_x == IMG_WIDTH - 1) begin
        m_x = 0;
        if (m_y == IMG_HEIGHT - 1) begin m_y = 0; m_active = 1'b0; end
        else m_y++;
      end else m_x++;
    end
    pend.busy = m_active;
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_i       = 1'b0;
    pix_valid_i = 1'b0;
    pix_sof_i   = 1'b0;
    m_active    = 1'b0;
    pend        = '{default: 0};
    expd        = pend;
    repeat (cycles) begin @(posedge clk_i); #1; end
    rst_i = 1'b1;
  endtask

  task automatic frame(input int p);
    for (int k = 0; k < IMG_WIDTH * IMG_HEIGHT; k++) drive(1'b1, k == 0, p);
  endtask

  task automatic check_lit(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got %0d exp %0d", name, got, exp);
  endtask

  task automatic check_ones_seq(input string name);
    int ref_seq [12];
    ref_seq = '{1, 2, 3, 4, 2, 4, 6, 8, 3, 6, 9, 12};
    check_lit({name, "_count"}, seen.size(), 12);
    for (int k = 0; k < 12 && k < seen.size(); k++) check_lit(name, seen[k], ref_seq[k]);
  endtask

  initial begin
    rst_i = 1'b0; pix_i = '0; pix_valid_i = 1'b0; pix_sof_i = 1'b0;
    m_active = 1'b0; m_x = 0; m_y = 0;
    pend = '{default: 0};
    expd = pend;
    for (int j = 0; j < IMG_HEIGHT; j++)
      for (int i = 0; i < IMG_WIDTH; i++) img[j][i] = 0;
    chk_en = 1'b1;
    do_reset(2);

    // All-ones frame
    seen.delete();
    frame(1);
    repeat (2) drive(1'b0, 1'b0, 0);
    check_ones_seq("ones_seq");

    // Ramp x+4y with valid toggling
    seen.delete();
    for (int k = 0; k < 12; k++) begin drive(1'b1, k == 0, k); drive(1'b0, 1'b0, 0); end
    drive(1'b0, 1'b0, 0);
    check_lit("ramp_count", seen.size(), 12);
    if (seen.size() > 0) check_lit("ramp_last", seen[$], 66);

    // Wrap-around, no saturation
    seen.delete();
    frame(255);
    repeat (2) drive(1'b0, 1'b0, 0);
    if (seen.size() > 0) check_lit("ff_last", seen[$], 244);

    // Pixels without sof are dropped
    do_reset(2);
    seen.delete();
    repeat (3) drive(1'b1, 1'b0, 5);
    repeat (2) drive(1'b0, 1'b0, 0);
    check_lit("nosof_count", seen.size(), 0);

    // Mid-frame sof at (2,1)
    seen.delete();
    for (int k = 0; k < 6; k++) drive(1'b1, k == 0, 1);
    frame(1);
    repeat (2) drive(1'b0, 1'b0, 0);
    check_lit("midsof_count", seen.size(), 18);
    if (seen.size() > 6) check_lit("midsof_restart", seen[6], 1);
    if (seen.size() > 0) check_lit("midsof_last", seen[$], 12);

    // Reset at (1,1), then a clean frame
    for (int k = 0; k < 5; k++) drive(1'b1, k == 0, 1);
    do_reset(3);
    seen.delete();
    frame(1);
    repeat (2) drive(1'b0, 1'b0, 0);
    check_ones_seq("postrst_seq");

    // Constant 2: ii ends at 24, squared ii at 48
    seen.delete();
    frame(2);
    repeat (2) drive(1'b0, 1'b0, 0);
    if (seen.size() > 0) check_lit("twos_last", seen[$], 24);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
